reg_bist: RTL and testbench

- Self-checking stimulus/response engine for clocked storage elements: the hardware-side counterpart of the bench that drives {d, reset} vectors into a register.
- Drives a fixed 4-vector sequence into a register-under-test (data plus synchronous clear), samples its output after the hold window, and compares against expected values.
- Reports pass/fail per vector.
- Sits beside dff / register instances for power-on or debug self-test of the CPU datapath registers.

---
 rtl/reg_bist_pkg.sv | 38 +++
 rtl/reg_bist_vector_rom.sv | 20 ++
 rtl/reg_bist.sv | 168 ++++++++++++++++
 tb/tb_reg_bist.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bist_pkg.sv
// Shared types and vector-table helpers for the register self-test engine.
package reg_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck
    } state_e;

    localparam int unsigned NumVectors = 4;
    localparam int unsigned VecIdxW    = 2;

    // ALT pattern is 0101..01 with the LSB set, so even bit positions are 1.
    function automatic logic alt_bit(input int unsigned b);
        return (b % 2) == 0;
    endfunction

    function automatic logic vec_d_bit(input logic [VecIdxW-1:0] idx, input int unsigned b);
        case (idx)
            2'd0, 2'd1: return alt_bit(b);
            2'd2:       return !alt_bit(b);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic vec_clr(input logic [VecIdxW-1:0] idx);
        return idx[0];
    endfunction

    function automatic logic vec_exp_bit(input logic [VecIdxW-1:0] idx, input int unsigned b);
        case (idx)
            2'd0:    return alt_bit(b);
            2'd2:    return !alt_bit(b);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_bist_vector_rom.sv
// Combinational vector table: index -> {drive data, clear, expected output}.
module reg_bist_vector_rom
    import reg_bist_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [VecIdxW-1:0] idx_i,
    output logic [WIDTH-1:0]   d_o,
    output logic               clr_o,
    output logic [WIDTH-1:0]   exp_o
);

    assign clr_o = vec_clr(idx_i);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d_o[i]   = vec_d_bit(idx_i, i);
        assign exp_o[i] = vec_exp_bit(idx_i, i);
    end

endmodule

// File: rtl/reg_bist.sv
// Drives a fixed 4-vector sequence into a register under test and scores its output.
module reg_bist
    import reg_bist_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic [WIDTH-1:0] dut_d_o,
    output logic             dut_clr_o,
    input  logic [WIDTH-1:0] dut_q_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [3:0]       fail_mask_o,
    output logic [2:0]       err_count_o
);

    localparam logic [3:0]         HoldInit = 4'(HOLD_CYCLES - 1);
    localparam logic [VecIdxW-1:0] LastIdx  = VecIdxW'(NumVectors - 1);

    state_e               state_q, state_d;
    logic [VecIdxW-1:0]   vec_idx_q, vec_idx_d;
    logic [3:0]           hold_cnt_q, hold_cnt_d;
    logic [3:0]           acc_mask_q, acc_mask_d;
    logic [2:0]           acc_cnt_q, acc_cnt_d;
    logic [WIDTH-1:0]     dut_d_q, dut_d_d;
    logic                 dut_clr_q, dut_clr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [3:0]           fail_mask_q, fail_mask_d;
    logic [2:0]           err_count_q, err_count_d;

    logic [VecIdxW-1:0]   nxt_idx;
    logic [WIDTH-1:0]     nxt_d, cur_exp;
    logic                 nxt_clr;
    logic [WIDTH-1:0]     unused_nxt_exp, unused_cur_d;
    logic                 unused_cur_clr;
    logic                 mismatch;
    logic [3:0]           mask_upd;
    logic [2:0]           cnt_upd;

    // Loads come from index 0 when starting, otherwise from the vector after the one checked.
    assign nxt_idx = (state_q == StCheck) ? vec_idx_q + 1'b1 : '0;

    reg_bist_vector_rom #(
        .WIDTH (WIDTH)
    ) u_rom_next (
        .idx_i (nxt_idx),
        .d_o   (nxt_d),
        .clr_o (nxt_clr),
        .exp_o (unused_nxt_exp)
    );

    reg_bist_vector_rom #(
        .WIDTH (WIDTH)
    ) u_rom_cur (
        .idx_i (vec_idx_q),
        .d_o   (unused_cur_d),
        .clr_o (unused_cur_clr),
        .exp_o (cur_exp)
    );

    assign mismatch = (dut_q_i != cur_exp);
    assign mask_upd = acc_mask_q | (4'(mismatch) << vec_idx_q);
    assign cnt_upd  = acc_cnt_q + 3'(mismatch);

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        hold_cnt_d  = hold_cnt_q;
        acc_mask_d  = acc_mask_q;
        acc_cnt_d   = acc_cnt_q;
        dut_d_d     = dut_d_q;
        dut_clr_d   = dut_clr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    vec_idx_d  = '0;
                    dut_d_d    = nxt_d;
                    dut_clr_d  = nxt_clr;
                    hold_cnt_d = HoldInit;
                    acc_mask_d = '0;
                    acc_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (hold_cnt_q == '0) begin
                    state_d = StCheck;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            StCheck: begin
                acc_mask_d = mask_upd;
                acc_cnt_d  = cnt_upd;
                if (vec_idx_q == LastIdx) begin
                    fail_mask_d = mask_upd;
                    err_count_d = cnt_upd;
                    pass_d      = (cnt_upd == '0);
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    dut_d_d     = '0;
                    dut_clr_d   = 1'b0;
                    vec_idx_d   = '0;
                    state_d     = StIdle;
                end else begin
                    vec_idx_d  = nxt_idx;
                    dut_d_d    = nxt_d;
                    dut_clr_d  = nxt_clr;
                    hold_cnt_d = HoldInit;
                    state_d    = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            vec_idx_q   <= '0;
            hold_cnt_q  <= '0;
            acc_mask_q  <= '0;
            acc_cnt_q   <= '0;
            dut_d_q     <= '0;
            dut_clr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            hold_cnt_q  <= hold_cnt_d;
            acc_mask_q  <= acc_mask_d;
            acc_cnt_q   <= acc_cnt_d;
            dut_d_q     <= dut_d_d;
            dut_clr_q   <= dut_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

    assign dut_d_o     = dut_d_q;
    assign dut_clr_o   = dut_clr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_mask_o = fail_mask_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_reg_bist.sv
// Scoreboard bench for reg_bist: a behavioural register model with injectable faults feeds dut_q.
module tb_reg_bist;

    localparam int unsigned W      = 8;
    localparam int unsigned H      = 2;
    localparam int          VecLen = H + 1;
    localparam int          RunLen = 4 * VecLen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dut_d, dut_q;
    logic         dut_clr, busy, done, pass;
    logic [3:0]   fail_mask;
    logic [2:0]   err_count;

    reg_bist #(
        .WIDTH       (W),
        .HOLD_CYCLES (H)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .dut_d_o     (dut_d),
        .dut_clr_o   (dut_clr),
        .dut_q_i     (dut_q),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .fail_mask_o (fail_mask),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register under test: 0 ideal, 1 ignores clear, 2 bit0 stuck at 0, 3 random garbage.
    int           fault_mode = 0;
    logic [W-1:0] rut_q = '0;
    always @(posedge clk) begin
        case (fault_mode)
            1:       rut_q <= dut_d;
            3:       rut_q <= W'($urandom);
            default: rut_q <= dut_clr ? '0 : dut_d;
        endcase
    end
    assign dut_q = (fault_mode == 2) ? {rut_q[W-1:1], 1'b0} : rut_q;

    logic [W-1:0] tbl_d   [4] = '{8'h55, 8'h55, 8'hAA, 8'hFF};
    logic         tbl_clr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] tbl_exp [4] = '{8'h55, 8'h00, 8'hAA, 8'h00};

    typedef struct {
        int         done_cyc;
        logic [3:0] mask;
        int         cnt;
        logic       pass;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What a register with the given fault would read back for each vector.
    function automatic exp_t model(input int mode, input int dcyc);
        exp_t         e;
        logic [W-1:0] q;
        e.done_cyc = dcyc;
        e.mask     = '0;
        e.cnt      = 0;
        for (int i = 0; i < 4; i++) begin
            if (mode == 1)      q = tbl_d[i];
            else if (tbl_clr[i]) q = '0;
            else                 q = tbl_d[i];
            if (mode == 2) q[0] = 1'b0;
            if (q != tbl_exp[i]) begin
                e.mask[i] = 1'b1;
                e.cnt++;
            end
        end
        e.pass = (e.cnt == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("pass", pass, e.pass);
                chk("fail_mask", fail_mask, e.mask);
                chk("err_count", err_count, e.cnt);
                chk("busy_at_done", busy, 0);
                chk("d_at_done", {dut_d, dut_clr}, 0);
            end
        end
    end

    task automatic issue_start(input int mode, output int e_edge);
        @(negedge clk);
        fault_mode = mode;
        start      = 1'b1;
        e_edge     = cyc + 1;
        sb.push_back(model(mode, e_edge + RunLen));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_drain"}, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int t;

        // Reset with random stimulus: everything stays zero.
        fault_mode = 3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            #1;
            chk("reset_outputs",
                {dut_d, dut_clr, busy, done, pass, fail_mask, err_count}, 0);
        end
        @(negedge clk);
        start      = 1'b0;
        fault_mode = 0;
        rst_n      = 1'b1;

        // Ideal register: check the drive sequence cycle by cycle.
        issue_start(0, e);
        for (int k = 0; k <= RunLen; k++) begin
            if (k > 0) @(negedge clk);
            chk("drive_d", dut_d, (k < RunLen) ? tbl_d[k / VecLen] : '0);
            chk("drive_clr", dut_clr, (k < RunLen) ? tbl_clr[k / VecLen] : 1'b0);
            chk("drive_busy", busy, (k < RunLen) ? 1 : 0);
        end
        wait_drain("ideal");

        issue_start(1, e);
        wait_drain("ignore_clear");
        issue_start(2, e);
        wait_drain("stuck_bit0");

        // Start pulsed mid-run is ignored; no extra done may follow.
        issue_start(0, e);
        while (cyc < e + 5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("start_busy");
        repeat (RunLen + 3) @(negedge clk);

        // Start held high: back-to-back runs, second one with a faulty register.
        @(negedge clk);
        fault_mode = 0;
        start      = 1'b1;
        e          = cyc + 1;
        sb.push_back(model(0, e + RunLen));
        sb.push_back(model(1, e + 2 * RunLen + 1));
        while (cyc < e + RunLen) @(negedge clk);
        fault_mode = 1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun_busy", busy, 1);
        repeat (5) @(negedge clk);
        chk("held_pass", pass, 1);
        chk("held_mask", fail_mask, 0);
        wait_drain("continuous");

        // Reset during v2 drive: asynchronous abort, no done.
        issue_start(0, e);
        while (cyc < e + 7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_d", dut_d, 0);
        chk("abort_clr", dut_clr, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_pass", pass, 0);
        repeat (RunLen + 3) @(negedge clk);
        issue_start(0, e);
        wait_drain("after_abort");

        // Randomised runs with random gaps, fault modes and ignored starts.
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            issue_start(int'($urandom_range(0, 2)), e);
            if ($urandom_range(0, 1) == 1) begin
                t = e + int'($urandom_range(1, 10));
                while (cyc < t) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_drain("random");
        end

        repeat (RunLen + 3) @(negedge clk);
        chk("final_queue", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
